ns_pkt_histogram: RTL and testbench

//  Passive monitor for a CMAC-style AXI-Stream (tap, never drives tready). Measures each packet's

---
 rtl/ns_pkt_histogram.sv | 152 +++++++++++++++
 tb/tb_ns_pkt_histogram.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ns_pkt_histogram.sv
`default_nettype none
// ============================================================================
// Module  : ns_pkt_histogram
// Brief   : Passive AXI-Stream tap that histograms packet byte lengths into
//           exact-length bins, bad/other counters and a running max length.
// Revision: 1.0
// ============================================================================
module ns_pkt_histogram #(
  parameter int                       DW       = 512,
  parameter int                       NUM_BINS = 4,
  // bin 0 occupies the low 16 bits
  parameter logic [NUM_BINS*16-1:0]   BIN_LENS = {16'd4160, 16'd1024, 16'd256, 16'd64},
  parameter int                       CW       = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [DW-1:0]            monitor_tdata,
  input  logic [DW/8-1:0]          monitor_tkeep,
  input  logic                     monitor_tlast,
  input  logic                     monitor_tuser,
  input  logic                     monitor_tvalid,
  input  logic                     monitor_tready,
  output logic [NUM_BINS*CW-1:0]   bin_count,
  output logic [CW-1:0]            bad_packets,
  output logic [CW-1:0]            other_packets,
  output logic [15:0]              max_len,
  output logic                     synced
);

  localparam int KW = DW / 8;

  typedef enum logic [0:0] {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_next;

  logic unused_tdata;
  assign unused_tdata = ^monitor_tdata;

  logic [7:0] kcount;
  always_comb begin
    kcount = '0;
    for (int k = 0; k < KW; k++) begin
      kcount = kcount + 8'(monitor_tkeep[k]);
    end
  end

  logic       s1_beat, s1_last, s1_user;
  logic [7:0] s1_kcount;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_beat   <= 1'b0;
      s1_last   <= 1'b0;
      s1_user   <= 1'b0;
      s1_kcount <= '0;
    end else begin
      s1_beat   <= monitor_tvalid & monitor_tready;
      s1_last   <= monitor_tlast;
      s1_user   <= monitor_tuser;
      s1_kcount <= kcount;
    end
  end

  logic [15:0] acc, len;
  logic [16:0] sum;
  assign sum = {1'b0, acc} + {9'd0, s1_kcount};
  assign len = sum[16] ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (s1_beat) begin
      acc <= s1_last ? 16'd0 : len;
    end
  end

  logic pkt_end;
  assign pkt_end = s1_beat & s1_last;

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_next;
  end

  logic classify;
  always_comb begin
    state_next = state;
    classify   = 1'b0;
    synced     = 1'b0;
    case (state)
      SYNC: begin
        if (pkt_end) state_next = ACTIVE;
      end
      ACTIVE: begin
        synced   = 1'b1;
        classify = pkt_end;
      end
      default: state_next = SYNC;
    endcase
  end

  // Lowest-index bin wins when lengths are duplicated.
  logic [NUM_BINS-1:0] hit;
  logic                matched;
  always_comb begin
    hit     = '0;
    matched = 1'b0;
    for (int i = 0; i < NUM_BINS; i++) begin
      if (!matched && len == BIN_LENS[16*i +: 16]) begin
        hit[i]  = 1'b1;
        matched = 1'b1;
      end
    end
  end

  logic good;
  assign good = classify & ~s1_user;

  generate
    for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
      logic [CW-1:0] cnt;
      always_ff @(posedge clk) begin
        if (reset || clear) begin
          cnt <= '0;
        end else if (good && hit[gi] && cnt != {CW{1'b1}}) begin
          cnt <= cnt + CW'(1);
        end
      end
      assign bin_count[CW*gi +: CW] = cnt;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bad_packets   <= '0;
      other_packets <= '0;
      max_len       <= '0;
    end else begin
      if (classify && s1_user && bad_packets != {CW{1'b1}})
        bad_packets <= bad_packets + CW'(1);
      if (good && !matched && other_packets != {CW{1'b1}})
        other_packets <= other_packets + CW'(1);
      if (good && len > max_len)
        max_len <= len;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ns_pkt_histogram.sv
`default_nettype none
// ============================================================================
// Module  : tb_ns_pkt_histogram
// Brief   : Directed, table-driven self-checking bench for ns_pkt_histogram.
// Revision: 1.0
// ============================================================================
module tb_ns_pkt_histogram;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int NB = 4;
  localparam int CW = 64;

  logic              clk = 1'b0;
  logic              reset, clear;
  logic [DW-1:0]     tdata;
  logic [KW-1:0]     tkeep;
  logic              tlast, tuser, tvalid, tready;
  logic [NB*CW-1:0]  bin_count;
  logic [CW-1:0]     bad_packets, other_packets;
  logic [15:0]       max_len;
  logic              synced;

  always #5 clk = ~clk;

  ns_pkt_histogram #(
    .DW(DW), .NUM_BINS(NB),
    .BIN_LENS({16'd4160, 16'd1024, 16'd256, 16'd64}), .CW(CW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .monitor_tdata(tdata), .monitor_tkeep(tkeep), .monitor_tlast(tlast),
    .monitor_tuser(tuser), .monitor_tvalid(tvalid), .monitor_tready(tready),
    .bin_count(bin_count), .bad_packets(bad_packets), .other_packets(other_packets),
    .max_len(max_len), .synced(synced)
  );

  int checks   = 0;
  int failures = 0;

  logic [CW-1:0] exp_bin [NB];
  logic [CW-1:0] exp_bad, exp_other;
  logic [15:0]   exp_max;
  logic          exp_synced;

  // cat: 0..3 = bin index, 4 = bad, 5 = other
  typedef struct {
    int          nbytes;
    bit          user;
    bit          stall;
    bit          empty_tail;
    int          cat;
    logic [15:0] exp_max;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NB; i++)
      chk($sformatf("%s bin%0d", tag, i), bin_count[CW*i +: CW], exp_bin[i]);
    chk({tag, " bad"},    bad_packets,   exp_bad);
    chk({tag, " other"},  other_packets, exp_other);
    chk({tag, " max_len"}, {48'd0, max_len}, {48'd0, exp_max});
    chk({tag, " synced"}, {63'd0, synced}, {63'd0, exp_synced});
  endtask

  task automatic model_zero();
    for (int i = 0; i < NB; i++) exp_bin[i] = '0;
    exp_bad   = '0;
    exp_other = '0;
    exp_max   = '0;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  task automatic model_count(input int cat, input logic [15:0] mx);
    if (cat < NB)       exp_bin[cat] = sat_inc(exp_bin[cat]);
    else if (cat == NB) exp_bad      = sat_inc(exp_bad);
    else                exp_other    = sat_inc(exp_other);
    exp_max = mx;
  endtask

  task automatic drive_beat(input int kb, input bit last, input bit user);
    logic [KW-1:0] m;
    m = (kb >= KW) ? {KW{1'b1}} : ((KW'(1) << kb) - KW'(1));
    tvalid = 1'b1; tready = 1'b1; tkeep = m; tlast = last; tuser = user;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0;
  endtask

  task automatic send_pkt(input int nbytes, input bit user, input bit stall, input bit empty_tail);
    int rem, kb;
    bit last;
    rem  = nbytes;
    last = 1'b0;
    while (!last) begin
      kb   = (rem > KW) ? KW : rem;
      rem -= kb;
      last = (rem == 0) && !empty_tail;
      if (stall) begin
        // Non-handshake cycles that look like a last beat must be ignored.
        tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tuser = 1'b1; tkeep = '1;
        @(posedge clk); #1;
        tvalid = 1'b0; tready = 1'b1;
        @(posedge clk); #1;
        tlast = 1'b0; tuser = 1'b0; tkeep = '0;
      end
      drive_beat(kb, last, last & user);
      if (rem == 0 && empty_tail) begin
        drive_beat(0, 1'b1, user);
        last = 1'b1;
      end
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{100,  1'b1, 1'b0, 1'b0, 4, 16'd64};
    vecs[1] = '{100,  1'b0, 1'b0, 1'b0, 5, 16'd100};
    vecs[2] = '{256,  1'b0, 1'b1, 1'b0, 1, 16'd256};
    vecs[3] = '{64,   1'b0, 1'b0, 1'b1, 0, 16'd256};
    vecs[4] = '{1024, 1'b0, 1'b1, 1'b0, 2, 16'd1024};
    vecs[5] = '{4160, 1'b1, 1'b0, 1'b0, 4, 16'd1024};
    vecs[6] = '{0,    1'b0, 1'b0, 1'b0, 5, 16'd1024};
    vecs[7] = '{65,   1'b0, 1'b1, 1'b0, 5, 16'd1024};
    vecs[8] = '{4160, 1'b0, 1'b0, 1'b0, 3, 16'd4160};

    reset = 1'b1; clear = 1'b0; tdata = '0; tkeep = '0;
    tlast = 1'b0; tuser = 1'b0; tvalid = 1'b0; tready = 1'b1;
    model_zero();
    exp_synced = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_all("reset");

    // First packet after reset only synchronises.
    send_pkt(64, 1'b0, 1'b0, 1'b0);
    settle();
    exp_synced = 1'b1;
    check_all("sync");

    send_pkt(4160, 1'b0, 1'b0, 1'b0);
    settle();
    model_count(3, 16'd4160);
    check_all("pkt4160");

    // Reset lands mid-packet: the tail must not be counted.
    for (int b = 0; b < 10; b++) drive_beat(KW, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_zero();
    exp_synced = 1'b0;
    check_all("midreset");
    send_pkt(55 * KW, 1'b0, 1'b0, 1'b0);
    settle();
    exp_synced = 1'b1;
    check_all("tail");
    send_pkt(64, 1'b0, 1'b0, 1'b0);
    settle();
    model_count(0, 16'd64);
    check_all("after_sync64");

    for (int v = 0; v < 9; v++) begin
      send_pkt(vecs[v].nbytes, vecs[v].user, vecs[v].stall, vecs[v].empty_tail);
      settle();
      model_count(vecs[v].cat, vecs[v].exp_max);
      check_all($sformatf("vec%0d", v));
    end

    // 1100 full beats saturate the length.
    send_pkt(1100 * KW, 1'b0, 1'b0, 1'b0);
    settle();
    model_count(5, 16'hFFFF);
    check_all("satlen");

    // Clear on the classify edge wins.
    send_pkt(256, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    settle();
    check_all("clear_coinc");
    send_pkt(256, 1'b0, 1'b0, 1'b0);
    settle();
    model_count(1, 16'd256);
    check_all("post_clear256");

    // Clear mid-packet keeps the accumulator intact.
    for (int b = 0; b < 8; b++) drive_beat(KW, 1'b0, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    model_zero();
    send_pkt(8 * KW, 1'b0, 1'b0, 1'b0);
    settle();
    model_count(2, 16'd1024);
    check_all("clear_inflight");

    // Saturation of a bin counter.
    force dut.g_bin[0].cnt = {CW{1'b1}};
    @(posedge clk); #1;
    release dut.g_bin[0].cnt;
    exp_bin[0] = {CW{1'b1}};
    check_all("preload");
    send_pkt(64, 1'b0, 1'b1, 1'b0);
    settle();
    model_count(0, 16'd1024);
    check_all("sat_bin0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
